// File: rtl/stage3_fetch_pkg.sv
// Shared types for the 3-stage pipeline fetch stage: FSM states, NOP word, IF/EX latch layout.
package stage3_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        mal;
  } ifex_latch_t;

endpackage

// File: rtl/stage3_pc_select.sv
// Next-PC priority mux: priv insertion beats fence rollback beats branch/jump beats pc+4.
module stage3_pc_select (
  input  logic        insert_priv_pc,
  input  logic [31:0] priv_pc,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        npc_sel,
  input  logic [31:0] brj_addr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect_req
);

  always_comb begin
    next_pc      = pc_plus4;
    redirect_req = 1'b1;
    if (insert_priv_pc) begin
      next_pc = priv_pc;
    end else if (rollback) begin
      next_pc = rollback_pc;
    end else if (npc_sel) begin
      next_pc = brj_addr;
    end else begin
      redirect_req = 1'b0;
    end
  end

endmodule

// File: rtl/stage3_fetch_stage.sv
// Fetch stage: owns the PC, drives the I-bus and the IF/EX latch; drops wrong-path responses.
// Optional misaligned-target trap path is enabled by defining STAGE3_FETCH_MISALIGN_CHECK_EN.
module stage3_fetch_stage
  import stage3_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic        npc_sel,
  input  logic [31:0] brj_addr,
  input  logic        insert_priv_pc,
  input  logic [31:0] priv_pc,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        if_ex_flush,
  input  logic        if_ex_stall,
  input  logic        suppress_iren,
  output logic        iren,
  output logic [31:0] iaddr,
  input  logic        i_mem_busy,
  input  logic [31:0] i_rdata,
  output logic        valid_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc4_f,
  output logic [31:0] instr_f,
  output logic        mal_insn_f
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_tgt_q, pc_tgt_d;
  logic [31:0]  hold_q, hold_d;
  logic         mal_done_q, mal_done_d;
  ifex_latch_t  ifex_q, ifex_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         redirect_req;
  logic         redirect;
  logic         mal_pc;
  logic         iren_c;
  logic         load_en;
  ifex_latch_t  load_val;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = pc_en & redirect_req;

`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
  assign mal_pc = |pc_q[1:0];
  assign iaddr  = pc_q;
`else
  assign mal_pc = 1'b0;
  assign iaddr  = {pc_q[31:2], 2'b00};
`endif

  stage3_pc_select u_pc_select (
    .insert_priv_pc (insert_priv_pc),
    .priv_pc        (priv_pc),
    .rollback       (rollback),
    .rollback_pc    (rollback_pc),
    .npc_sel        (npc_sel),
    .brj_addr       (brj_addr),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc),
    .redirect_req   (redirect_req)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_tgt_d   = pc_tgt_q;
    hold_d     = hold_q;
    mal_done_d = mal_done_q;
    iren_c     = 1'b0;
    load_en    = 1'b0;
    load_val   = '0;

    unique case (state_q)
      FETCH: begin
        if (mal_pc) begin
          // A misaligned target is reported once and then fetch idles until the trap redirect.
          if (redirect) begin
            pc_d       = next_pc;
            mal_done_d = 1'b0;
          end else if (!mal_done_q && !if_ex_stall && !if_ex_flush) begin
            load_en    = 1'b1;
            load_val   = ifex_latch_t'{valid: 1'b1, pc: pc_q, pc4: pc_plus4,
                                       instr: NOP_INSN, mal: 1'b1};
            mal_done_d = 1'b1;
          end
        end else begin
          iren_c = !suppress_iren;
          if (iren_c && !i_mem_busy) begin
            if (redirect) begin
              pc_d = next_pc;
            end else if (!if_ex_stall) begin
              load_en  = 1'b1;
              load_val = ifex_latch_t'{valid: 1'b1, pc: pc_q, pc4: pc_plus4,
                                       instr: i_rdata, mal: 1'b0};
              if (pc_en) pc_d = pc_plus4;
            end else begin
              hold_d  = i_rdata;
              state_d = HOLD;
            end
          end else if (iren_c) begin
            if (redirect) begin
              pc_tgt_d = next_pc;
              state_d  = DISCARD;
            end
          end else if (redirect) begin
            pc_d = next_pc;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end else if (!if_ex_stall) begin
          load_en  = 1'b1;
          load_val = ifex_latch_t'{valid: 1'b1, pc: pc_q, pc4: pc_plus4,
                                   instr: hold_q, mal: 1'b0};
          pc_d     = pc_plus4;
          state_d  = FETCH;
        end
      end

      DISCARD: begin
        // The stale beat keeps its address until it completes; the newest redirect wins.
        iren_c = 1'b1;
        if (redirect) pc_tgt_d = next_pc;
        if (!i_mem_busy) begin
          pc_d    = pc_tgt_d;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ifex_d = ifex_q;
    if (if_ex_flush) begin
      ifex_d.valid = 1'b0;
      ifex_d.instr = NOP_INSN;
      ifex_d.mal   = 1'b0;
    end else if (if_ex_stall) begin
      ifex_d = ifex_q;
    end else if (load_en) begin
      ifex_d = load_val;
    end else begin
      ifex_d.valid = 1'b0;
      ifex_d.mal   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pc_tgt_q   <= RESET_PC;
      hold_q     <= NOP_INSN;
      mal_done_q <= 1'b0;
      ifex_q     <= ifex_latch_t'{valid: 1'b0, pc: 32'h0, pc4: 32'h0,
                                  instr: NOP_INSN, mal: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_tgt_q   <= pc_tgt_d;
      hold_q     <= hold_d;
      mal_done_q <= mal_done_d;
      ifex_q     <= ifex_d;
    end
  end

  // The request is masked by reset directly so the bus sees it drop without waiting for a clock.
  assign iren       = iren_c & nRST;
  assign valid_f    = ifex_q.valid;
  assign pc_f       = ifex_q.pc;
  assign pc4_f      = ifex_q.pc4;
  assign instr_f    = ifex_q.instr;
  assign mal_insn_f = ifex_q.mal;

endmodule
